// File: rtl/i2c_target_sync.sv
// Brings raw SCL/SDA into the clk domain and flags SCL edges and bus START/STOP.
// Flops reset to 1 so that a reset looks like an idle bus.
module i2c_target_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [SYNC_LEN-1:0] scl_sync_q;
  logic [SYNC_LEN-1:0] sda_sync_q;
  logic                scl_prev_q;
  logic                sda_prev_q;
  logic                scl_s;
  logic                sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int i = 1; i < SYNC_LEN; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_LEN-1];
  assign sda_s      = sda_sync_q[SYNC_LEN-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SCL must be high on both samples so an SDA change near an SCL edge is not misread.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
endmodule

// File: rtl/i2c_target_wb.sv
// I2C target with a 16-byte register file, auto-incrementing pointer and a
// single-beat Wishbone-style port for host access to the same registers.
module i2c_target_wb #(
  parameter logic [6:0] I2C_ADDR = 7'h42,
  parameter int         SYNC_LEN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [4:0]  wb_addr,
  output logic [31:0] wb_rdata,
  input  logic [31:0] wb_wdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack
);
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR     = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK = 4'd2;
  localparam logic [3:0] ST_PTR      = 4'd3;
  localparam logic [3:0] ST_WDATA    = 4'd4;
  localparam logic [3:0] ST_WACK     = 4'd5;
  localparam logic [3:0] ST_RDATA    = 4'd6;
  localparam logic [3:0] ST_RACK     = 4'd7;
  localparam logic [3:0] ST_IGNORE   = 4'd8;
  localparam logic [4:0] STATUS_ADDR = 5'h10;

  typedef enum logic [3:0] {
    IDLE = ST_IDLE, ADDR = ST_ADDR, ADDR_ACK = ST_ADDR_ACK, PTR = ST_PTR,
    WDATA = ST_WDATA, WACK = ST_WACK, RDATA = ST_RDATA, RACK = ST_RACK,
    IGNORE = ST_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        i2c_we;
  logic [7:0]  regs_q [16];
  logic [7:0]  cur_byte;
  logic        wr_event_q;
  logic        wb_cyc_q;
  logic        wb_ack_q;
  logic [31:0] wb_rdata_q;
  logic [31:0] rd_mux;
  logic        wb_fire;
  logic        busy;
  logic        sda_s, scl_rise, scl_fall, start, stop;
  logic        unused_wdata;

  i2c_target_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  assign cur_byte = regs_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    i2c_we    = 1'b0;
    if (start) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            if (state_q == ADDR) begin
              if (rx_q[7:1] == I2C_ADDR) begin
                state_d = ADDR_ACK;
              end else begin
                state_d  = IGNORE;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == PTR) begin
              ptr_d   = rx_q[3:0];
              state_d = WACK;
            end else begin
              i2c_we  = 1'b1;
              ptr_d   = ptr_q + 4'd1;
              state_d = WACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rx_q[0]) begin
              tx_d     = cur_byte;
              sda_oe_d = ~cur_byte[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = PTR;
            end
          end
        end
        WACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        RACK: begin
          // A NACK leaves on the rising edge, so a falling edge here means ACK.
          if (scl_rise) begin
            if (sda_s) state_d = IGNORE;
            else       ptr_d   = ptr_q + 4'd1;
          end else if (scl_fall) begin
            tx_d     = cur_byte;
            sda_oe_d = ~cur_byte[7];
            state_d  = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_fire      = wb_cyc & ~wb_cyc_q;
  assign busy         = (state_q != IDLE) && (state_q != IGNORE);
  assign unused_wdata = ^{wb_wdata[31:8], wb_wdata[0]};

  always_comb begin
    rd_mux = 32'd0;
    if (!wb_addr[4])                rd_mux = {24'd0, regs_q[wb_addr[3:0]]};
    else if (wb_addr == STATUS_ADDR) rd_mux = {20'd0, ptr_q, 6'd0, wr_event_q, busy};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      rx_q       <= 8'd0;
      tx_q       <= 8'd0;
      ptr_q      <= 4'd0;
      sda_oe_q   <= 1'b0;
      wr_event_q <= 1'b0;
      wb_cyc_q   <= 1'b0;
      wb_ack_q   <= 1'b0;
      wb_rdata_q <= 32'd0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      wb_cyc_q   <= wb_cyc;
      wb_ack_q   <= wb_fire;
      wb_rdata_q <= wb_fire ? rd_mux : 32'd0;
      // The bus master cannot be held off, so its write wins any collision.
      for (int i = 0; i < 16; i++) begin
        if (i2c_we && ptr_q == 4'(i))
          regs_q[i] <= rx_q;
        else if (wb_fire && wb_we && wb_addr == 5'(i))
          regs_q[i] <= wb_wdata[7:0];
      end
      if (i2c_we)
        wr_event_q <= 1'b1;
      else if (wb_fire && wb_we && wb_addr == STATUS_ADDR && wb_wdata[1])
        wr_event_q <= 1'b0;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wb_ack   = wb_ack_q;
  assign wb_rdata = wb_rdata_q;
endmodule

// File: tb/tb_i2c_target_wb.sv
// Directed bench: bit-banged I2C master on an open-drain SDA model plus host-port accesses.
module tb_i2c_target_wb;
  localparam int Q = 8;

  logic        clk;
  logic        rst;
  logic        scl_m;
  logic        sda_m;
  logic        sda_line;
  logic        sda_oe;
  logic [4:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  int tests = 0;
  int fails = 0;
  int oe_hits = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_wb #(.I2C_ADDR(7'h42), .SYNC_LEN(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .wb_addr  (wb_addr),
    .wb_rdata (wb_rdata),
    .wb_wdata (wb_wdata),
    .wb_we    (wb_we),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] check %s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sda_oe) oe_hits++;
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clks(Q);
    scl_m = 1'b1; wait_clks(2 * Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    b = sda_line; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic nack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(nack);
  endtask

  // Host write timed to land on the same clk edge as the target's byte commit:
  // two synchronizer flops plus the edge-detect flop after the last SCL fall.
  task automatic write_byte_coll(input logic [7:0] d, input logic [4:0] a,
                                 input logic [31:0] wd, output logic nack);
    for (int i = 7; i >= 1; i--) write_bit(d[i]);
    sda_m = d[0]; wait_clks(Q);
    scl_m = 1'b1; wait_clks(2 * Q);
    scl_m = 1'b0; wait_clks(2);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = wd;
    wait_clks(1);
    wb_cyc = 1'b0; wb_we = 1'b0;
    wait_clks(Q - 3);
    read_bit(nack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(master_ack);
  endtask

  task automatic wb_xfer(input logic we, input logic [4:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic ackd);
    wb_cyc = 1'b1; wb_we = we; wb_addr = a; wb_wdata = wd;
    wait_clks(1);
    ackd = wb_ack;
    rd   = wb_rdata;
    wb_cyc = 1'b0; wb_we = 1'b0;
    wait_clks(1);
  endtask

  initial begin
    logic        nack;
    logic        ackd;
    logic        b;
    logic [7:0]  rbyte;
    logic [31:0] rd;
    int          ack_cnt;
    int          first_ack;
    int          rbad;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    wb_cyc = 1'b0; wb_we = 1'b0; wb_addr = 5'd0; wb_wdata = 32'd0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(2);

    // Reset state
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_wb_ack", wb_ack, 1'b0);
    check("rst_wb_rdata", wb_rdata, 32'd0);
    wb_xfer(1'b0, 5'h10, 32'd0, rd, ackd);
    check("rst_status_ack", ackd, 1'b1);
    check("rst_status", rd, 32'h0000_0000);
    wb_xfer(1'b0, 5'h05, 32'd0, rd, ackd);
    check("rst_reg5", rd, 32'h0);

    // Write 0x03 <- A5, 5A
    i2c_start();
    write_byte(8'h84, nack); check("w1_addr_ack", nack, 1'b0);
    write_byte(8'h03, nack); check("w1_ptr_ack", nack, 1'b0);
    write_byte(8'hA5, nack); check("w1_d0_ack", nack, 1'b0);
    write_byte(8'h5A, nack); check("w1_d1_ack", nack, 1'b0);
    i2c_stop();
    wb_xfer(1'b0, 5'h03, 32'd0, rd, ackd); check("w1_reg3", rd, 32'h0000_00A5);
    wb_xfer(1'b0, 5'h04, 32'd0, rd, ackd); check("w1_reg4", rd, 32'h0000_005A);
    wb_xfer(1'b0, 5'h10, 32'd0, rd, ackd); check("w1_status", rd, 32'h0000_0502);
    wb_xfer(1'b1, 5'h10, 32'h2, rd, ackd);
    wb_xfer(1'b0, 5'h10, 32'd0, rd, ackd); check("wr_event_clear", rd, 32'h0000_0500);
    wb_xfer(1'b1, 5'h11, 32'hFFFF_FFFF, rd, ackd);
    wb_xfer(1'b0, 5'h11, 32'd0, rd, ackd); check("reserved_read", rd, 32'h0);

    // Host preload, then pointer 0x0F and repeated-START read across the wrap
    wb_xfer(1'b1, 5'h0F, 32'h11, rd, ackd);
    wb_xfer(1'b1, 5'h00, 32'h22, rd, ackd);
    i2c_start();
    write_byte(8'h84, nack); check("r1_addr_ack", nack, 1'b0);
    wb_xfer(1'b0, 5'h10, 32'd0, rd, ackd); check("r1_busy_status", rd, 32'h0000_0501);
    write_byte(8'h0F, nack); check("r1_ptr_ack", nack, 1'b0);
    i2c_start();
    write_byte(8'h85, nack); check("r1_raddr_ack", nack, 1'b0);
    read_byte(1'b0, rbyte);  check("r1_byte0", rbyte, 8'h11);
    read_byte(1'b1, rbyte);  check("r1_byte1_wrap", rbyte, 8'h22);
    check("r1_oe_after_nack", sda_oe, 1'b0);
    i2c_stop();
    wb_xfer(1'b0, 5'h10, 32'd0, rd, ackd); check("r1_status", rd, 32'h0000_0000);

    // Wrong address: never drives SDA, nothing written
    oe_hits = 0;
    i2c_start();
    write_byte(8'h86, nack); check("bad_addr_nack", nack, 1'b1);
    write_byte(8'h01, nack); check("bad_ptr_nack", nack, 1'b1);
    write_byte(8'h77, nack); check("bad_data_nack", nack, 1'b1);
    i2c_stop();
    check("bad_oe_cycles", oe_hits, 0);
    wb_xfer(1'b0, 5'h01, 32'd0, rd, ackd); check("bad_reg1", rd, 32'h0);
    wb_xfer(1'b0, 5'h10, 32'd0, rd, ackd); check("bad_status", rd, 32'h0);

    // Reset in the middle of a read byte of zeros (target pulling SDA low)
    i2c_start();
    write_byte(8'h84, nack); check("rr_addr_ack", nack, 1'b0);
    write_byte(8'h02, nack); check("rr_ptr_ack", nack, 1'b0);
    i2c_start();
    write_byte(8'h85, nack); check("rr_raddr_ack", nack, 1'b0);
    for (int i = 0; i < 3; i++) read_bit(b);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(2);
    check("rr_oe_before_rst", sda_oe, 1'b1);
    rst = 1'b1; wait_clks(1);
    check("rr_oe_after_rst", sda_oe, 1'b0);
    rst = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
    i2c_stop();
    wb_xfer(1'b0, 5'h00, 32'd0, rd, ackd); check("rr_reg0_cleared", rd, 32'h0);

    // Same-edge collisions: reg7 (I2C 0x33 vs host 0x44), wr_event set vs clear
    i2c_start();
    write_byte(8'h84, nack); check("rr_next_addr_ack", nack, 1'b0);
    write_byte(8'h07, nack); check("col_ptr_ack", nack, 1'b0);
    write_byte_coll(8'h33, 5'h07, 32'h44, nack); check("col_d0_ack", nack, 1'b0);
    write_byte_coll(8'h55, 5'h10, 32'h2, nack);  check("col_d1_ack", nack, 1'b0);
    i2c_stop();
    wb_xfer(1'b0, 5'h07, 32'd0, rd, ackd); check("col_reg7", rd, 32'h33);
    wb_xfer(1'b0, 5'h08, 32'd0, rd, ackd); check("col_reg8", rd, 32'h55);
    wb_xfer(1'b0, 5'h10, 32'd0, rd, ackd); check("col_status", rd, 32'h0000_0902);

    // Host cycle held 5 cycles: single ack in cycle 2, rdata zero otherwise
    wb_addr = 5'h07; wb_we = 1'b0; wb_cyc = 1'b1;
    ack_cnt = 0; first_ack = 0; rbad = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (wb_ack) begin
        ack_cnt++;
        if (first_ack == 0) first_ack = c;
        if (wb_rdata !== 32'h33) rbad++;
      end else if (wb_rdata !== 32'h0) begin
        rbad++;
      end
      @(posedge clk); #1;
    end
    wb_cyc = 1'b0;
    wait_clks(2);
    check("hold_ack_count", ack_cnt, 1);
    check("hold_ack_cycle", first_ack, 2);
    check("hold_rdata_gating", rbad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
